// File: rtl/rggen_bus_arbiter_pkg.sv
// Shared types for the rggen bus arbiter: FSM states and response status encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The status encoding matches rggen_rtl_pkg::rggen_status, so downstream responses
// pass through untranslated.
package rggen_bus_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    REQUEST = 1'b1
  } rggen_bus_arbiter_state_e;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  // Status returned to the granted requester when the downstream bus never answers.
  localparam logic [1:0] RGGEN_BUS_ARBITER_TIMEOUT_STATUS = RGGEN_SLAVE_ERROR;

endpackage

// File: rtl/rggen_round_robin_selector.sv
// Round-robin pick: first asserted request searching upward from last_grant+1, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to use the result.
//
// Ports:
//   i_request     N-bit request vector
//   i_last_grant  index of the most recent winner
//   o_grant       one-hot winner, all zero when no request is present
module rggen_round_robin_selector #(
  parameter int N_REQUESTERS = 2,
  parameter int INDEX_WIDTH  = 1
) (
  input  logic [N_REQUESTERS-1:0] i_request,
  input  logic [INDEX_WIDTH-1:0]  i_last_grant,
  output logic [N_REQUESTERS-1:0] o_grant
);

  logic w_found;
  int   w_index;

  // Offsets 1..N visit every requester exactly once, the previous winner last.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_index = 0;
    for (int off = 1; off <= N_REQUESTERS; off++) begin
      w_index = (int'(i_last_grant) + off) % N_REQUESTERS;
      if (!w_found && i_request[w_index]) begin
        o_grant[w_index] = 1'b1;
        w_found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Shares one downstream register bus between N requesters, round-robin, one transfer outstanding.
// Latency: slave valid in cycle t -> master valid in t+1; response passes back combinationally.
// Backpressure: master valid/payload held until master ready; losing requesters wait (ready=0).
//
// Optional feature macro: RGGEN_BUS_ARBITER_TIMEOUT_EN (forced SLAVE_ERROR response after
// TIMEOUT_CYCLES cycles in REQUEST without downstream ready).
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_slave_*               per-requester request (valid, write, address, write_data, strobe), packed by index
//   o_slave_*               per-requester response (ready, status, read_data), packed by index
//   o_master_*              shared downstream request
//   i_master_*              shared downstream response (ready, status, read_data)
//   o_grant                 one-hot owner, 0 when idle
//   o_busy                  1 while a transfer is outstanding
module rggen_bus_arbiter
  import rggen_bus_arbiter_pkg::*;
#(
  parameter int N_REQUESTERS   = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [N_REQUESTERS-1:0]              i_slave_valid,
  input  logic [N_REQUESTERS-1:0]              i_slave_write,
  input  logic [N_REQUESTERS*ADDRESS_WIDTH-1:0] i_slave_address,
  input  logic [N_REQUESTERS*BUS_WIDTH-1:0]    i_slave_write_data,
  input  logic [N_REQUESTERS*BUS_WIDTH/8-1:0]  i_slave_strobe,
  output logic [N_REQUESTERS-1:0]              o_slave_ready,
  output logic [N_REQUESTERS*2-1:0]            o_slave_status,
  output logic [N_REQUESTERS*BUS_WIDTH-1:0]    o_slave_read_data,
  output logic                                 o_master_valid,
  output logic                                 o_master_write,
  output logic [ADDRESS_WIDTH-1:0]             o_master_address,
  output logic [BUS_WIDTH-1:0]                 o_master_write_data,
  output logic [BUS_WIDTH/8-1:0]               o_master_strobe,
  input  logic                                 i_master_ready,
  input  logic [1:0]                           i_master_status,
  input  logic [BUS_WIDTH-1:0]                 i_master_read_data,
  output logic [N_REQUESTERS-1:0]              o_grant,
  output logic                                 o_busy
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int INDEX_WIDTH  = $clog2(N_REQUESTERS);

  rggen_bus_arbiter_state_e r_state;
  rggen_bus_arbiter_state_e w_next_state;

  logic [N_REQUESTERS-1:0]  r_grant;
  logic [INDEX_WIDTH-1:0]   r_last_grant;
  logic                     r_valid;
  logic                     r_write;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [BUS_WIDTH-1:0]     r_write_data;
  logic [STROBE_WIDTH-1:0]  r_strobe;

  logic [N_REQUESTERS-1:0]  w_select;
  logic [INDEX_WIDTH-1:0]   w_select_index;
  logic                     w_load;
  logic                     w_done;
  logic                     w_timeout;

  rggen_round_robin_selector #(
    .N_REQUESTERS (N_REQUESTERS),
    .INDEX_WIDTH  (INDEX_WIDTH)
  ) u_selector (
    .i_request    (i_slave_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_select)
  );

  always_comb begin
    w_select_index = '0;
    for (int i = 0; i < N_REQUESTERS; i++) begin
      if (w_select[i]) begin
        w_select_index = INDEX_WIDTH'(i);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state and transfer strobes
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|i_slave_valid) begin
          w_load       = 1'b1;
          w_next_state = REQUEST;
        end
      end
      REQUEST: begin
        if (i_master_ready || w_timeout) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Ownership and downstream valid; last_grant starts at the top index so index 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid      <= 1'b0;
      r_grant      <= '0;
      r_last_grant <= INDEX_WIDTH'(N_REQUESTERS - 1);
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_grant      <= w_select;
      r_last_grant <= w_select_index;
    end else if (w_done) begin
      r_valid      <= 1'b0;
      r_grant      <= '0;
    end
  end

  // Payload only matters while r_valid is set, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (w_load) begin
      r_write      <= i_slave_write[w_select_index];
      r_address    <= i_slave_address[int'(w_select_index)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      r_write_data <= i_slave_write_data[int'(w_select_index)*BUS_WIDTH +: BUS_WIDTH];
      r_strobe     <= i_slave_strobe[int'(w_select_index)*STROBE_WIDTH +: STROBE_WIDTH];
    end
  end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [COUNT_WIDTH-1:0] r_timeout_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timeout_count <= '0;
    end else if (w_load) begin
      r_timeout_count <= '0;
    end else if ((r_state == REQUEST) && !i_master_ready) begin
      r_timeout_count <= r_timeout_count + COUNT_WIDTH'(1);
    end
  end

  // A real downstream ready in the final cycle wins over the forced error.
  assign w_timeout = (r_state == REQUEST) && !i_master_ready &&
                     (r_timeout_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Response routing: r_grant is non-zero only in REQUEST, so it alone gates every requester.
  always_comb begin
    o_slave_ready     = '0;
    o_slave_status    = '0;
    o_slave_read_data = '0;
    for (int i = 0; i < N_REQUESTERS; i++) begin
      if (r_grant[i]) begin
        o_slave_ready[i] = w_done;
        if (w_timeout) begin
          o_slave_status[i*2 +: 2] = RGGEN_BUS_ARBITER_TIMEOUT_STATUS;
        end else begin
          o_slave_status[i*2 +: 2]                = i_master_status;
          o_slave_read_data[i*BUS_WIDTH +: BUS_WIDTH] = i_master_read_data;
        end
      end
    end
  end

  assign o_master_valid      = r_valid;
  assign o_master_write      = r_write;
  assign o_master_address    = r_address;
  assign o_master_write_data = r_write_data;
  assign o_master_strobe     = r_strobe;
  assign o_grant             = r_grant;
  assign o_busy              = (r_state == REQUEST);

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter with two requesters and an 8-cycle timeout parameter.
module tb_rggen_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int TO = 8;

  localparam logic [1:0] ST_OKAY   = 2'b00;
  localparam logic [1:0] ST_EXOKAY = 2'b01;
  localparam logic [1:0] ST_SLVERR = 2'b10;

  logic              i_clk;
  logic              i_rst_n;
  logic [N-1:0]      i_slave_valid;
  logic [N-1:0]      i_slave_write;
  logic [N*AW-1:0]   i_slave_address;
  logic [N*BW-1:0]   i_slave_write_data;
  logic [N*BW/8-1:0] i_slave_strobe;
  logic [N-1:0]      o_slave_ready;
  logic [N*2-1:0]    o_slave_status;
  logic [N*BW-1:0]   o_slave_read_data;
  logic              o_master_valid;
  logic              o_master_write;
  logic [AW-1:0]     o_master_address;
  logic [BW-1:0]     o_master_write_data;
  logic [BW/8-1:0]   o_master_strobe;
  logic              i_master_ready;
  logic [1:0]        i_master_status;
  logic [BW-1:0]     i_master_read_data;
  logic [N-1:0]      o_grant;
  logic              o_busy;

  int passed = 0;
  int total  = 0;

  rggen_bus_arbiter #(
    .N_REQUESTERS   (N),
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_slave_valid       (i_slave_valid),
    .i_slave_write       (i_slave_write),
    .i_slave_address     (i_slave_address),
    .i_slave_write_data  (i_slave_write_data),
    .i_slave_strobe      (i_slave_strobe),
    .o_slave_ready       (o_slave_ready),
    .o_slave_status      (o_slave_status),
    .o_slave_read_data   (o_slave_read_data),
    .o_master_valid      (o_master_valid),
    .o_master_write      (o_master_write),
    .o_master_address    (o_master_address),
    .o_master_write_data (o_master_write_data),
    .o_master_strobe     (o_master_strobe),
    .i_master_ready      (i_master_ready),
    .i_master_status     (i_master_status),
    .i_master_read_data  (i_master_read_data),
    .o_grant             (o_grant),
    .o_busy              (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_slave_valid      = '0;
    i_slave_write      = '0;
    i_slave_address    = '0;
    i_slave_write_data = '0;
    i_slave_strobe     = '0;
    i_master_ready     = 1'b0;
    i_master_status    = ST_OKAY;
    i_master_read_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_master_ready = 1'b1;
    i_rst_n = 1'b0;
    #12;
    total++; if (o_master_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_master_valid); else passed++;
    total++; if (o_grant !== 2'b00) $display("FAIL reset_grant got %b want 00", o_grant); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", o_busy); else passed++;
    total++; if (o_slave_ready !== 2'b00) $display("FAIL reset_ready got %b want 00", o_slave_ready); else passed++;
    tick();
    i_master_ready = 1'b0;
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    i_slave_valid[0]          = 1'b1;
    i_slave_write[0]          = 1'b1;
    i_slave_address[7:0]      = 8'h10;
    i_slave_write_data[31:0]  = 32'hA5A5A5A5;
    i_slave_strobe[3:0]       = 4'hF;
    #1;
    total++; if (o_master_valid !== 1'b0) $display("FAIL single_valid_early got %b want 0", o_master_valid); else passed++;
    tick();
    total++; if (o_master_valid !== 1'b1) $display("FAIL single_valid got %b want 1", o_master_valid); else passed++;
    total++; if (o_grant !== 2'b01) $display("FAIL single_grant got %b want 01", o_grant); else passed++;
    total++; if (o_busy !== 1'b1) $display("FAIL single_busy got %b want 1", o_busy); else passed++;
    total++; if (o_master_address !== 8'h10) $display("FAIL single_addr got %h want 10", o_master_address); else passed++;
    total++; if (o_master_write_data !== 32'hA5A5A5A5) $display("FAIL single_wdata got %h want a5a5a5a5", o_master_write_data); else passed++;
    total++; if (o_master_strobe !== 4'hF) $display("FAIL single_strobe got %h want f", o_master_strobe); else passed++;
    total++; if (o_master_write !== 1'b1) $display("FAIL single_write got %b want 1", o_master_write); else passed++;
    total++; if (o_slave_ready !== 2'b00) $display("FAIL single_ready_wait got %b want 00", o_slave_ready); else passed++;
    tick();
    tick();
    tick();
    total++; if (o_master_valid !== 1'b1) $display("FAIL single_valid_hold got %b want 1", o_master_valid); else passed++;
    total++; if (o_master_address !== 8'h10) $display("FAIL single_addr_hold got %h want 10", o_master_address); else passed++;
    i_master_ready = 1'b1;
    #1;
    total++; if (o_slave_ready !== 2'b01) $display("FAIL single_ready got %b want 01", o_slave_ready); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (o_master_valid !== 1'b0) $display("FAIL single_valid_drop got %b want 0", o_master_valid); else passed++;
    total++; if (o_grant !== 2'b00) $display("FAIL single_grant_drop got %b want 00", o_grant); else passed++;
    total++; if (o_slave_ready !== 2'b00) $display("FAIL single_ready_drop got %b want 00", o_slave_ready); else passed++;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_grant [4];
    logic [7:0] exp_addr  [4];
    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr  = '{8'h20, 8'h31, 8'h20, 8'h31};
    test_reset();
    i_slave_valid   = 2'b11;
    i_slave_address = {8'h31, 8'h20};
    i_master_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (o_grant !== exp_grant[k]) $display("FAIL contention_grant%0d got %b want %b", k, o_grant, exp_grant[k]); else passed++;
      total++; if (o_master_address !== exp_addr[k]) $display("FAIL contention_addr%0d got %h want %h", k, o_master_address, exp_addr[k]); else passed++;
      total++; if (o_slave_ready !== exp_grant[k]) $display("FAIL contention_ready%0d got %b want %b", k, o_slave_ready, exp_grant[k]); else passed++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_read_data();
    i_slave_valid[1]       = 1'b1;
    i_slave_write[1]       = 1'b0;
    i_slave_address[15:8]  = 8'h44;
    tick();
    total++; if (o_grant !== 2'b10) $display("FAIL read1_grant got %b want 10", o_grant); else passed++;
    total++; if (o_master_write !== 1'b0) $display("FAIL read1_write got %b want 0", o_master_write); else passed++;
    total++; if (o_slave_ready !== 2'b00) $display("FAIL read1_ready_wait got %b want 00", o_slave_ready); else passed++;
    i_master_ready     = 1'b1;
    i_master_status    = ST_OKAY;
    i_master_read_data = 32'h12345678;
    #1;
    total++; if (o_slave_ready !== 2'b10) $display("FAIL read1_ready got %b want 10", o_slave_ready); else passed++;
    total++; if (o_slave_read_data[63:32] !== 32'h12345678) $display("FAIL read1_rdata got %h want 12345678", o_slave_read_data[63:32]); else passed++;
    total++; if (o_slave_status[3:2] !== ST_OKAY) $display("FAIL read1_status got %b want 00", o_slave_status[3:2]); else passed++;
    total++; if (o_slave_read_data[31:0] !== 32'h0) $display("FAIL read1_other_rdata got %h want 0", o_slave_read_data[31:0]); else passed++;
    tick();
    clear_inputs();
    i_slave_valid[0]      = 1'b1;
    i_slave_address[7:0]  = 8'h08;
    tick();
    total++; if (o_grant !== 2'b01) $display("FAIL read0_grant got %b want 01", o_grant); else passed++;
    i_master_ready     = 1'b1;
    i_master_status    = ST_EXOKAY;
    i_master_read_data = 32'hDEADBEEF;
    #1;
    total++; if (o_slave_status[1:0] !== ST_EXOKAY) $display("FAIL read0_status got %b want 01", o_slave_status[1:0]); else passed++;
    total++; if (o_slave_read_data[31:0] !== 32'hDEADBEEF) $display("FAIL read0_rdata got %h want deadbeef", o_slave_read_data[31:0]); else passed++;
    total++; if (o_slave_status[3:2] !== 2'b00) $display("FAIL read0_other_status got %b want 00", o_slave_status[3:2]); else passed++;
    total++; if (o_slave_read_data[63:32] !== 32'h0) $display("FAIL read0_other_rdata got %h want 0", o_slave_read_data[63:32]); else passed++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    i_slave_valid[0] = 1'b1;
    tick();
    total++; if (o_busy !== 1'b1) $display("FAIL midrst_busy_before got %b want 1", o_busy); else passed++;
    i_master_ready = 1'b1;
    i_rst_n = 1'b0;
    #1;
    total++; if (o_master_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", o_master_valid); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", o_busy); else passed++;
    total++; if (o_grant !== 2'b00) $display("FAIL midrst_grant got %b want 00", o_grant); else passed++;
    total++; if (o_slave_ready !== 2'b00) $display("FAIL midrst_ready got %b want 00", o_slave_ready); else passed++;
    i_slave_valid  = 2'b11;
    i_master_ready = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    total++; if (o_grant !== 2'b01) $display("FAIL midrst_first_grant got %b want 01", o_grant); else passed++;
    i_master_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    i_slave_valid[1]   = 1'b1;
    i_master_read_data = 32'hFFFFFFFF;
    i_master_status    = ST_EXOKAY;
    tick();
    for (int k = 1; k < TO; k++) begin
      total++; if (o_slave_ready !== 2'b00) $display("FAIL timeout_wait%0d got %b want 00", k, o_slave_ready); else passed++;
      tick();
    end
    total++; if (o_slave_ready !== 2'b10) $display("FAIL timeout_ready got %b want 10", o_slave_ready); else passed++;
    total++; if (o_slave_status[3:2] !== ST_SLVERR) $display("FAIL timeout_status got %b want 10", o_slave_status[3:2]); else passed++;
    total++; if (o_slave_read_data[63:32] !== 32'h0) $display("FAIL timeout_rdata got %h want 0", o_slave_read_data[63:32]); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (o_busy !== 1'b0) $display("FAIL timeout_idle got %b want 0", o_busy); else passed++;
    total++; if (o_master_valid !== 1'b0) $display("FAIL timeout_valid_drop got %b want 0", o_master_valid); else passed++;
    tick();
  endtask

  task automatic test_timeout_edge();
    i_slave_valid[0] = 1'b1;
    tick();
    for (int k = 1; k < TO; k++) tick();
    i_master_ready     = 1'b1;
    i_master_status    = ST_EXOKAY;
    i_master_read_data = 32'hCAFEF00D;
    #1;
    total++; if (o_slave_ready !== 2'b01) $display("FAIL tedge_ready got %b want 01", o_slave_ready); else passed++;
    total++; if (o_slave_status[1:0] !== ST_EXOKAY) $display("FAIL tedge_status got %b want 01", o_slave_status[1:0]); else passed++;
    total++; if (o_slave_read_data[31:0] !== 32'hCAFEF00D) $display("FAIL tedge_rdata got %h want cafef00d", o_slave_read_data[31:0]); else passed++;
    tick();
    clear_inputs();
    #1;
    total++; if (o_busy !== 1'b0) $display("FAIL tedge_idle got %b want 0", o_busy); else passed++;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    i_slave_valid[1] = 1'b1;
    tick();
    repeat (20) tick();
    total++; if (o_busy !== 1'b1) $display("FAIL notimeout_busy got %b want 1", o_busy); else passed++;
    total++; if (o_master_valid !== 1'b1) $display("FAIL notimeout_valid got %b want 1", o_master_valid); else passed++;
    total++; if (o_slave_ready !== 2'b00) $display("FAIL notimeout_ready got %b want 00", o_slave_ready); else passed++;
    i_master_ready = 1'b1;
    #1;
    total++; if (o_slave_ready !== 2'b10) $display("FAIL notimeout_final_ready got %b want 10", o_slave_ready); else passed++;
    tick();
    clear_inputs();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_read_data();
    test_reset_mid_transfer();
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    test_timeout();
    test_timeout_edge();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
